uart_fifo_core: RTL
===================

// Module: uart_fifo_core
// PURPOSE
//  Parametrised full-duplex UART engine: TX and RX shifters with programmable bit period and word
//  length, a TX FIFO and an RX FIFO with valid/ready handshakes, and sticky error flags. Sits
//  between the bus-interface logic (status/data registers) and the tx/rx pins. Replaces the fixed
//  9600-baud, 8-bit, single-buffer TX/RX pair.
// PARAMETERS
//  CLK_DIV     1667  clk cycles per bit; legal range 4..65535
//  DATA_BITS   8     data bits per frame; 5..8, sent LSB first
//  FIFO_DEPTH  4     entries per FIFO (TX and RX each); power of 2, >=2
//  PARITY_ODD  0     used only with UART_PARITY_EN; 0 = even parity, 1 = odd parity
// PORTS
//  clk           in   1                     system clock
//  nrst          in   1                     asynchronous reset, active low
//  tx_data       in   DATA_BITS             word to transmit
//  tx_valid      in   1                     tx_data present
//  tx_ready      out  1                     TX FIFO not full; push on tx_valid&&tx_ready
//  tx_busy       out  1                     TX FIFO non-empty or a frame is on the line
//  tx            out  1                     serial out, idle high
//  rx            in   1                     serial in, asynchronous
//  rx_data       out  DATA_BITS             head of RX FIFO (show-ahead)
//  rx_valid      out  1                     RX FIFO not empty
//  rx_ready      in   1                     pop on rx_valid&&rx_ready
//  rx_count      out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy
//  rx_overrun    out  1                     sticky: a received word was dropped because the FIFO was full
//  rx_frame_err  out  1                     sticky: stop bit sampled low
//  rx_parity_err out  1                     sticky: parity mismatch (tied 0 without the macro)
//  clr_err       in   1                     one-cycle pulse clears all sticky flags
// BEHAVIOUR
//  Reset (nrst low, takes effect immediately): tx=1, both FIFOs empty, tx_ready=1, tx_busy=0,
//   rx_valid=0, rx_count=0, all error flags 0, rx_data=0, both FSMs IDLE, rx synchroniser=11.
//  FIFOs: circular, pointers carry one extra wrap bit. A push to a full FIFO is refused (TX) or
//   dropped (RX). A pop and a push in the same cycle on a full FIFO both succeed; no overrun.
//  TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. Every state lasts exactly CLK_DIV
//   cycles. The FSM loads the shifter from the FIFO head in IDLE when the FIFO is non-empty. tx
//   goes low 1 cycle after the load. Latency from a push into an empty, idle core to tx falling
//   edge: 2 cycles. At the end of STOP, a non-empty FIFO goes straight to START with no idle gap.
//   There is one stop bit. The frame is CLK_DIV*(DATA_BITS+2[+1]) cycles long.
//  RX front end: 2-flop synchroniser on rx. A falling edge on the synchronised rx in IDLE enters
//   START and loads the bit counter with CLK_DIV/2.
//  RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. Each sample is taken when the
//   counter expires; the counter is then reloaded with CLK_DIV-1. If the mid-start sample is 1,
//   the event is a glitch: return to IDLE with no flag. Data bits shift in LSB first.
//  Stop sample 0: set rx_frame_err and discard the word. After a frame error, IDLE waits for rx=1
//   before re-arming edge detection.
//  Stop sample 1 and no parity error: push the word. If the FIFO is full, drop the word and set
//   rx_overrun.
//  The FSM returns to IDLE straight after the stop sample (mid-bit), so back-to-back frames are
//   received.
//  Sticky flags: set wins over a clr_err in the same cycle. The flags do not block reception.
//  Mid-frame reset: tx goes high immediately and any partial words in either direction are lost.
// CONFIGURATION
//  UART_PARITY_EN defined: TX appends a parity bit after the data. The bit is the XOR of the data,
//   inverted when PARITY_ODD=1. RX samples and checks it; on a mismatch it sets rx_parity_err and
//   discards the word (the stop bit is still checked).
//  UART_PARITY_EN undefined: no parity state in either FSM; rx_parity_err is constant 0.
// TESTING (CLK_DIV=16, DATA_BITS=8, FIFO_DEPTH=4, tx looped to rx unless stated)
//  Reset: hold nrst low mid-frame -> tx=1 and rx_valid=0 at once, all flags 0, tx_ready=1.
//  Push 0xA5 -> tx low for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high;
//   160-cycle frame; rx_data=0xA5, rx_valid=1.
//  Push 0x00,0xFF,0x55,0xAA,0x3C back-to-back with rx_ready=0 -> tx_ready drops while the TX FIFO
//   is full; no idle gap between frames; rx_count=4 and rx_overrun=1. Popping then yields
//   0x00,0xFF,0x55,0xAA. Pulse clr_err -> rx_overrun=0.
//  Drive rx low for 4 cycles only -> no word, no flags, and the FSM is back in IDLE.
//  Drive frame 0x41 with the stop bit low -> rx_frame_err=1 and rx_valid stays 0. A following
//   valid frame 0x42 is received.
//  With UART_PARITY_EN and PARITY_ODD=0: push 0x01 -> parity bit 1 on tx. Inject frame 0x01 with
//   parity 0 -> rx_parity_err=1 and the word is discarded.

Source files
------------

// File: rtl/uart_fifo_core.sv
// Full-duplex UART engine: TX/RX shifters, per-direction FIFOs and sticky error flags.
// Optional parity bit in both directions is enabled by defining UART_PARITY_EN.

module uart_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [W-1:0]           data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           data_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         empty, full, do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);
    assign count_o = wptr_q - rptr_q;
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end
endmodule

module uart_fifo_core #(
    parameter int CLK_DIV    = 1667,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk_i,
    input  logic                          nrst_i,
    input  logic [DATA_BITS-1:0]          tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic                          tx_busy_o,
    output logic                          tx_o,
    input  logic                          rx_i,
    output logic [DATA_BITS-1:0]          rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count_o,
    output logic                          rx_overrun_o,
    output logic                          rx_frame_err_o,
    output logic                          rx_parity_err_o,
    input  logic                          clr_err_i
);
    localparam int             CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0]    DIV_M1   = 16'(CLK_DIV - 1);
    localparam logic [15:0]    DIV_HALF = 16'(CLK_DIV / 2);
    localparam logic [3:0]     LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    // ---------------- TX path ----------------
    logic [DATA_BITS-1:0] tx_head;
    logic [CW-1:0]        tx_cnt;
    logic                 tx_empty, tx_push, tx_load;

    state_t               tx_st_q;
    logic [15:0]          tx_tmr_q;
    logic [3:0]           tx_bit_q;
    logic [DATA_BITS-1:0] tx_sh_q;
    logic                 tx_q;
`ifdef UART_PARITY_EN
    logic                 tx_par_q;
`endif

    assign tx_empty   = (tx_cnt == '0);
    assign tx_ready_o = (tx_cnt != FULL_CNT);
    assign tx_push    = tx_valid_i && tx_ready_o;
    // Load from IDLE, or straight out of the last STOP cycle so frames run back to back.
    assign tx_load    = !tx_empty &&
                        ((tx_st_q == S_IDLE) || (tx_st_q == S_STOP && tx_tmr_q == '0));
    assign tx_busy_o  = !tx_empty || (tx_st_q != S_IDLE);
    assign tx_o       = tx_q;

    uart_sync_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (nrst_i),
        .push_i  (tx_push),
        .data_i  (tx_data_i),
        .pop_i   (tx_load),
        .data_o  (tx_head),
        .count_o (tx_cnt)
    );

    // tx is the line level of the current state, registered: it trails the state by one cycle.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            tx_st_q  <= S_IDLE;
            tx_tmr_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q <= 1'b0;
`endif
        end else begin
            case (tx_st_q)
                S_START:  tx_q <= 1'b0;
                S_DATA:   tx_q <= tx_sh_q[0];
`ifdef UART_PARITY_EN
                S_PARITY: tx_q <= tx_par_q;
`endif
                default:  tx_q <= 1'b1;
            endcase

            if (tx_load) begin
                tx_sh_q  <= tx_head;
                tx_tmr_q <= DIV_M1;
                tx_st_q  <= S_START;
`ifdef UART_PARITY_EN
                tx_par_q <= (^tx_head) ^ (PARITY_ODD != 0);
`endif
            end else if (tx_st_q != S_IDLE) begin
                if (tx_tmr_q != '0) begin
                    tx_tmr_q <= tx_tmr_q - 16'd1;
                end else begin
                    tx_tmr_q <= DIV_M1;
                    case (tx_st_q)
                        S_START: begin
                            tx_st_q  <= S_DATA;
                            tx_bit_q <= '0;
                        end
                        S_DATA: begin
                            tx_sh_q  <= tx_sh_q >> 1;
                            tx_bit_q <= tx_bit_q + 4'd1;
                            if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                                tx_st_q <= S_PARITY;
`else
                                tx_st_q <= S_STOP;
`endif
                            end
                        end
`ifdef UART_PARITY_EN
                        S_PARITY: tx_st_q <= S_STOP;
`endif
                        default:  tx_st_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

    // ---------------- RX path ----------------
    logic                 rx_s1_q, rx_s2_q, rx_prev_q, rx_wait_q;
    state_t               rx_st_q;
    logic [15:0]          rx_tmr_q;
    logic [3:0]           rx_bit_q;
    logic [DATA_BITS-1:0] rx_sh_q;
    logic                 rx_push_q, rx_ferr_set_q;
`ifdef UART_PARITY_EN
    logic                 rx_perr_q, rx_perr_set_q;
`endif
    logic                 rx_pop, ovr_set;

    assign rx_valid_o = (rx_count_o != '0);
    assign rx_pop     = rx_valid_o && rx_ready_i;
    assign ovr_set    = rx_push_q && (rx_count_o == FULL_CNT) && !rx_pop;

    uart_sync_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (nrst_i),
        .push_i  (rx_push_q),
        .data_i  (rx_sh_q),
        .pop_i   (rx_pop),
        .data_o  (rx_data_o),
        .count_o (rx_count_o)
    );

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            rx_prev_q     <= 1'b1;
            rx_wait_q     <= 1'b0;
            rx_st_q       <= S_IDLE;
            rx_tmr_q      <= '0;
            rx_bit_q      <= '0;
            rx_sh_q       <= '0;
            rx_push_q     <= 1'b0;
            rx_ferr_set_q <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr_q     <= 1'b0;
            rx_perr_set_q <= 1'b0;
`endif
        end else begin
            rx_s1_q       <= rx_i;
            rx_s2_q       <= rx_s1_q;
            rx_prev_q     <= rx_s2_q;
            rx_push_q     <= 1'b0;
            rx_ferr_set_q <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr_set_q <= 1'b0;
`endif
            if (rx_st_q == S_IDLE) begin
                // After a bad stop bit the line may still be low; wait for it to idle first.
                if (rx_wait_q) begin
                    if (rx_s2_q) rx_wait_q <= 1'b0;
                end else if (rx_prev_q && !rx_s2_q) begin
                    rx_st_q  <= S_START;
                    rx_tmr_q <= DIV_HALF;
                end
            end else if (rx_tmr_q != '0) begin
                rx_tmr_q <= rx_tmr_q - 16'd1;
            end else begin
                rx_tmr_q <= DIV_M1;
                case (rx_st_q)
                    S_START: begin
                        if (rx_s2_q) begin
                            rx_st_q <= S_IDLE;
                        end else begin
                            rx_st_q  <= S_DATA;
                            rx_bit_q <= '0;
`ifdef UART_PARITY_EN
                            rx_perr_q <= 1'b0;
`endif
                        end
                    end
                    S_DATA: begin
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                        rx_bit_q <= rx_bit_q + 4'd1;
                        if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            rx_st_q <= S_PARITY;
`else
                            rx_st_q <= S_STOP;
`endif
                        end
                    end
`ifdef UART_PARITY_EN
                    S_PARITY: begin
                        rx_perr_q <= rx_s2_q != ((^rx_sh_q) ^ (PARITY_ODD != 0));
                        rx_st_q   <= S_STOP;
                    end
`endif
                    S_STOP: begin
                        rx_st_q <= S_IDLE;
                        if (!rx_s2_q) begin
                            rx_ferr_set_q <= 1'b1;
                            rx_wait_q     <= 1'b1;
                        end
`ifdef UART_PARITY_EN
                        rx_perr_set_q <= rx_perr_q;
                        if (rx_s2_q && !rx_perr_q) rx_push_q <= 1'b1;
`else
                        if (rx_s2_q) rx_push_q <= 1'b1;
`endif
                    end
                    default: rx_st_q <= S_IDLE;
                endcase
            end
        end
    end

    // ---------------- sticky flags (set beats clear) ----------------
    logic ovr_q, ovr_d, ferr_q, ferr_d;

    always_comb begin
        ovr_d  = ovr_q;
        ferr_d = ferr_q;
        if (clr_err_i) begin
            ovr_d  = 1'b0;
            ferr_d = 1'b0;
        end
        if (ovr_set)       ovr_d  = 1'b1;
        if (rx_ferr_set_q) ferr_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovr_q  <= ovr_d;
            ferr_q <= ferr_d;
        end
    end

    assign rx_overrun_o   = ovr_q;
    assign rx_frame_err_o = ferr_q;

`ifdef UART_PARITY_EN
    logic perr_q, perr_d;

    always_comb begin
        perr_d = perr_q;
        if (clr_err_i)     perr_d = 1'b0;
        if (rx_perr_set_q) perr_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) perr_q <= 1'b0;
        else         perr_q <= perr_d;
    end

    assign rx_parity_err_o = perr_q;
`else
    // Without a parity bit PARITY_ODD has no effect; the flag is constant 0 for legal values.
    assign rx_parity_err_o = (PARITY_ODD < 0);
`endif
endmodule
